// File: rtl/icache_direct_pkg.sv
// rtl/icache_direct_pkg.sv - shared constants for the direct-mapped instruction cache
//
// Purpose: boolean constants, FSM state encodings and the default index width
//          used by icache_direct and icache_array.
// Ports:   none (package).
package icache_direct_pkg;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    // 64 lines of one 32-bit word each
    localparam int ICACHE_INDEX_BITS = 6;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_MISS = 1'b1;

endpackage

// File: rtl/icache_direct_if.sv
// rtl/icache_direct_if.sv - fetcher and memory-controller bus of the instruction cache
//
// Purpose: groups the fetch request/response and the memory word request/return.
// Signals: fetch_valid, fetch_pc[31:0]   fetcher -> cache request
//          fetch_ready, fetch_inst[31:0] cache -> fetcher response (combinational)
//          mem_valid, mem_addr[31:0]     cache -> controller word request
//          mem_enable, mem_data[31:0]    controller -> cache one-cycle word return
// Modports: slave (cache side), master (fetcher/controller side).
interface icache_direct_if;

    logic        fetch_valid;
    logic [31:0] fetch_pc;
    logic        fetch_ready;
    logic [31:0] fetch_inst;
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic        mem_enable;
    logic [31:0] mem_data;

    modport slave (
        input  fetch_valid, fetch_pc, mem_enable, mem_data,
        output fetch_ready, fetch_inst, mem_valid, mem_addr
    );

    modport master (
        output fetch_valid, fetch_pc, mem_enable, mem_data,
        input  fetch_ready, fetch_inst, mem_valid, mem_addr
    );

endinterface

// File: rtl/icache_array.sv
// rtl/icache_array.sv - valid/tag/data storage for the direct-mapped instruction cache
//
// Purpose: 2^INDEX_BITS lines, combinational read, one write port, valid bits
//          cleared synchronously on rst (tag/data are left unreset).
// Ports:   clk, rst                          clock, synchronous active-high reset
//          rd_idx_i -> rd_valid_o/rd_tag_o/rd_data_o   combinational read
//          we_i, wr_idx_i, wr_tag_i, wr_data_i         write port
import icache_direct_pkg::*;

module icache_array #(
    parameter int INDEX_BITS = ICACHE_INDEX_BITS,
    parameter int TAG_BITS   = 30 - INDEX_BITS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [INDEX_BITS-1:0] rd_idx_i,
    output logic                  rd_valid_o,
    output logic [TAG_BITS-1:0]   rd_tag_o,
    output logic [31:0]           rd_data_o,
    input  logic                  we_i,
    input  logic [INDEX_BITS-1:0] wr_idx_i,
    input  logic [TAG_BITS-1:0]   wr_tag_i,
    input  logic [31:0]           wr_data_i
);

    localparam int LINES = 1 << INDEX_BITS;

    logic [LINES-1:0]    valid_q;
    logic [TAG_BITS-1:0] tag_q  [LINES];
    logic [31:0]         data_q [LINES];

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else if (we_i) begin
            valid_q[wr_idx_i] <= TRUE;
        end
    end

    always_ff @(posedge clk) begin
        if (we_i) begin
            tag_q[wr_idx_i]  <= wr_tag_i;
            data_q[wr_idx_i] <= wr_data_i;
        end
    end

    assign rd_valid_o = valid_q[rd_idx_i];
    assign rd_tag_o   = tag_q[rd_idx_i];
    assign rd_data_o  = data_q[rd_idx_i];

endmodule

// File: rtl/icache_direct.sv
// rtl/icache_direct.sv - direct-mapped one-word-per-line instruction cache
//
// Purpose: serves hits combinationally; on a miss holds a single word request
//          to the memory controller, refills the line and bypasses the word.
//          clear abandons an outstanding miss (mispredict) without writing.
// Ports:   clk, rst    clock, synchronous active-high reset
//          rdy         global ready; low freezes state, array and registers
//          clear       abandon outstanding fetch, suppress hits
//          bus         icache_direct_if.slave (fetch and memory sides)
//          stat_hits, stat_misses   wrapping counters, present only when
//                                   ICACHE_STATS_EN is defined
import icache_direct_pkg::*;

module icache_direct #(
    parameter int INDEX_BITS = ICACHE_INDEX_BITS,
    parameter int TAG_BITS   = 30 - INDEX_BITS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rdy,
    input  logic                 clear,
    icache_direct_if.slave       bus
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0]          stat_hits,
    output logic [31:0]          stat_misses
`endif
);

    logic [0:0]            state_q, state_d;
    logic                  mem_valid_q, mem_valid_d;
    logic [31:0]           mem_addr_q, mem_addr_d;

    logic [INDEX_BITS-1:0] rd_idx, wr_idx;
    logic [TAG_BITS-1:0]   req_tag, rd_tag, wr_tag;
    logic                  rd_valid;
    logic [31:0]           rd_data;
    logic                  hit, refill, miss_start;
    logic                  unused_pc_bits;

    // mem_addr_q doubles as the latched miss address for the refill write
    assign rd_idx  = bus.fetch_pc[INDEX_BITS+1:2];
    assign req_tag = bus.fetch_pc[31:INDEX_BITS+2];
    assign wr_idx  = mem_addr_q[INDEX_BITS+1:2];
    assign wr_tag  = mem_addr_q[31:INDEX_BITS+2];
    assign unused_pc_bits = ^{bus.fetch_pc[1:0], mem_addr_q[1:0]};

    assign hit = bus.fetch_valid & rd_valid & (rd_tag == req_tag)
               & (state_q == S_IDLE) & ~clear;
    // mem_enable is meaningless while rdy is low, so the bypass waits too
    assign refill     = rdy & (state_q == S_MISS) & bus.mem_enable & ~clear;
    assign miss_start = rdy & (state_q == S_IDLE) & bus.fetch_valid & ~hit & ~clear;

    assign bus.fetch_ready = hit | refill;
    assign bus.fetch_inst  = (state_q == S_MISS) ? bus.mem_data : rd_data;
    assign bus.mem_valid   = mem_valid_q;
    assign bus.mem_addr    = mem_addr_q;

    icache_array #(
        .INDEX_BITS (INDEX_BITS),
        .TAG_BITS   (TAG_BITS)
    ) u_array (
        .clk        (clk),
        .rst        (rst),
        .rd_idx_i   (rd_idx),
        .rd_valid_o (rd_valid),
        .rd_tag_o   (rd_tag),
        .rd_data_o  (rd_data),
        .we_i       (refill),
        .wr_idx_i   (wr_idx),
        .wr_tag_i   (wr_tag),
        .wr_data_i  (bus.mem_data)
    );

    always_comb begin
        state_d     = state_q;
        mem_valid_d = mem_valid_q;
        mem_addr_d  = mem_addr_q;
        if (rdy) begin
            case (state_q)
                S_IDLE: begin
                    if (miss_start) begin
                        mem_valid_d = TRUE;
                        mem_addr_d  = {bus.fetch_pc[31:2], 2'b00};
                        state_d     = S_MISS;
                    end else begin
                        mem_valid_d = FALSE;
                    end
                end
                S_MISS: begin
                    // clear wins over mem_enable; dropping mem_valid is the abort
                    if (clear | bus.mem_enable) begin
                        mem_valid_d = FALSE;
                        state_d     = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            mem_valid_q <= FALSE;
            mem_addr_q  <= '0;
        end else begin
            state_q     <= state_d;
            mem_valid_q <= mem_valid_d;
            mem_addr_q  <= mem_addr_d;
        end
    end

`ifdef ICACHE_STATS_EN
    logic [31:0] hits_q, misses_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            hits_q   <= '0;
            misses_q <= '0;
        end else if (rdy) begin
            if (hit)        hits_q   <= hits_q + 32'd1;
            if (miss_start) misses_q <= misses_q + 32'd1;
        end
    end

    assign stat_hits   = hits_q;
    assign stat_misses = misses_q;
`endif

    // the fetcher must hold its pc while a miss is outstanding
    pc_stable_in_miss: assert property (@(posedge clk) disable iff (rst)
        (rdy && state_q == S_MISS && !clear && bus.fetch_valid)
        |-> (bus.fetch_pc[31:2] == mem_addr_q[31:2]));

endmodule

// File: tb/tb_icache_direct.sv
// tb/tb_icache_direct.sv - directed scoreboard bench for icache_direct
module tb_icache_direct;

    logic clk = 1'b0;
    logic rst, rdy, clear;
    icache_direct_if bus();
`ifdef ICACHE_STATS_EN
    logic [31:0] stat_hits, stat_misses;
`endif

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] exp_addr_q [$];
    logic [31:0] exp_inst_q [$];

    always #5 clk = ~clk;

    icache_direct dut (
        .clk   (clk),
        .rst   (rst),
        .rdy   (rdy),
        .clear (clear),
        .bus   (bus)
`ifdef ICACHE_STATS_EN
        ,
        .stat_hits   (stat_hits),
        .stat_misses (stat_misses)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // issue a fetch that must miss; wait (bounded) for the request, return word
    task automatic do_miss(input logic [31:0] pc, input logic [31:0] word);
        int n;
        exp_addr_q.push_back({pc[31:2], 2'b00});
        exp_inst_q.push_back(word);
        bus.fetch_valid = 1'b1;
        bus.fetch_pc    = pc;
        @(negedge clk);
        chk1("miss_req_ready", bus.fetch_ready, 1'b0);
        chk1("miss_req_memv", bus.mem_valid, 1'b0);
        n = 0;
        do begin
            tick();
            n++;
        end while (!bus.mem_valid && n < 8);
        chk("miss_latency", 32'(n), 32'd1);
        chk1("mem_valid_up", bus.mem_valid, 1'b1);
        chk("mem_addr", bus.mem_addr, exp_addr_q.pop_front());
        bus.mem_enable = 1'b1;
        bus.mem_data   = word;
        @(negedge clk);
        chk1("refill_ready", bus.fetch_ready, 1'b1);
        chk("refill_inst", bus.fetch_inst, exp_inst_q.pop_front());
        tick();
        bus.mem_enable  = 1'b0;
        bus.mem_data    = '0;
        bus.fetch_valid = 1'b0;
        chk1("mem_valid_drop", bus.mem_valid, 1'b0);
    endtask

    task automatic do_hit(input logic [31:0] pc, input logic [31:0] word);
        exp_inst_q.push_back(word);
        bus.fetch_valid = 1'b1;
        bus.fetch_pc    = pc;
        @(negedge clk);
        chk1("hit_ready", bus.fetch_ready, 1'b1);
        chk("hit_inst", bus.fetch_inst, exp_inst_q.pop_front());
        chk1("hit_no_memv", bus.mem_valid, 1'b0);
        tick();
        bus.fetch_valid = 1'b0;
        chk1("hit_no_req", bus.mem_valid, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; rdy = 1'b1; clear = 1'b0;
        bus.fetch_valid = 1'b1; bus.fetch_pc = 32'h0000_0100;
        bus.mem_enable = 1'b0; bus.mem_data = '0;
        repeat (3) tick();
        @(negedge clk);
        chk1("rst_ready", bus.fetch_ready, 1'b0);
        chk1("rst_memv", bus.mem_valid, 1'b0);
        chk("rst_addr", bus.mem_addr, 32'h0);
        tick();
        bus.fetch_valid = 1'b0;
        rst = 1'b0;
        tick();

        // cold miss then three hits
        do_miss(32'h0000_0100, 32'h00A0_0093);
        do_hit(32'h0000_0100, 32'h00A0_0093);
        do_hit(32'h0000_0100, 32'h00A0_0093);
        do_hit(32'h0000_0100, 32'h00A0_0093);
`ifdef ICACHE_STATS_EN
        chk("stat_misses", stat_misses, 32'd1);
        chk("stat_hits", stat_hits, 32'd3);
`endif

        // conflict eviction at index 0
        do_miss(32'h0000_0200, 32'h1111_1111);
        do_hit(32'h0000_0200, 32'h1111_1111);
        do_miss(32'h0000_0100, 32'h00A0_0093);
        do_hit(32'h0000_0100, 32'h00A0_0093);

        // clear in IDLE suppresses a hit and issues no request
        bus.fetch_valid = 1'b1; bus.fetch_pc = 32'h0000_0100; clear = 1'b1;
        @(negedge clk);
        chk1("clr_idle_ready", bus.fetch_ready, 1'b0);
        tick();
        bus.fetch_valid = 1'b0; clear = 1'b0;
        chk1("clr_idle_memv", bus.mem_valid, 1'b0);

        // clear mid-miss, later mem_enable ignored, line stays invalid
        bus.fetch_valid = 1'b1; bus.fetch_pc = 32'h0000_0104;
        tick();
        chk1("cm_memv", bus.mem_valid, 1'b1);
        clear = 1'b1; bus.fetch_valid = 1'b0;
        @(negedge clk);
        chk1("cm_ready", bus.fetch_ready, 1'b0);
        tick();
        clear = 1'b0;
        chk1("cm_drop", bus.mem_valid, 1'b0);
        bus.mem_enable = 1'b1; bus.mem_data = 32'hDEAD_0104;
        @(negedge clk);
        chk1("cm_late_en", bus.fetch_ready, 1'b0);
        tick();
        bus.mem_enable = 1'b0;
        chk1("cm_late_memv", bus.mem_valid, 1'b0);
        do_miss(32'h0000_0104, 32'h0010_0113);
        do_hit(32'h0000_0104, 32'h0010_0113);

        // clear coincident with mem_enable: no bypass, no write
        bus.fetch_valid = 1'b1; bus.fetch_pc = 32'h0000_0108;
        tick();
        chk("cc_addr", bus.mem_addr, 32'h0000_0108);
        clear = 1'b1; bus.mem_enable = 1'b1; bus.mem_data = 32'hBAD0_BAD0;
        @(negedge clk);
        chk1("cc_ready", bus.fetch_ready, 1'b0);
        tick();
        clear = 1'b0; bus.mem_enable = 1'b0; bus.fetch_valid = 1'b0;
        chk1("cc_drop", bus.mem_valid, 1'b0);
        do_miss(32'h0000_0108, 32'h0020_8093);

        // rdy low for three cycles during MISS
        exp_addr_q.push_back(32'h0000_010C);
        exp_inst_q.push_back(32'h0040_006F);
        bus.fetch_valid = 1'b1; bus.fetch_pc = 32'h0000_010C;
        tick();
        chk1("rdy_memv", bus.mem_valid, 1'b1);
        rdy = 1'b0; bus.mem_enable = 1'b1; bus.mem_data = 32'hDEAD_BEEF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk1("rdy_lo_ready", bus.fetch_ready, 1'b0);
            tick();
            chk1("rdy_lo_memv", bus.mem_valid, 1'b1);
            chk("rdy_lo_addr", bus.mem_addr, 32'h0000_010C);
        end
        rdy = 1'b1; bus.mem_enable = 1'b0;
        @(negedge clk);
        chk1("rdy_back_ready", bus.fetch_ready, 1'b0);
        tick();
        chk1("rdy_back_memv", bus.mem_valid, 1'b1);
        chk("rdy_back_addr", bus.mem_addr, exp_addr_q.pop_front());
        bus.mem_enable = 1'b1; bus.mem_data = 32'h0040_006F;
        @(negedge clk);
        chk1("rdy_refill_ready", bus.fetch_ready, 1'b1);
        chk("rdy_refill_inst", bus.fetch_inst, exp_inst_q.pop_front());
        tick();
        bus.mem_enable = 1'b0; bus.fetch_valid = 1'b0;
        chk1("rdy_refill_drop", bus.mem_valid, 1'b0);
        do_hit(32'h0000_010C, 32'h0040_006F);

        // earlier lines survive
        do_hit(32'h0000_0100, 32'h00A0_0093);
        do_hit(32'h0000_0108, 32'h0020_8093);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
